imem_loader: RTL
================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter MEM_BYTES, default 256, instruction-memory size in bytes.
REQ-002 Parameter MAX_WORDS, default 64 (MEM_BYTES/4), largest loadable program in words.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle request to begin a program load.
REQ-006 word_count  input  7  number of 32-bit words to load, sampled when start is accepted.
REQ-007 in_valid  input  1  byte-stream source has a byte on in_data.
REQ-008 in_data  input  8  program byte, stream order = ascending memory byte address.
REQ-009 in_ready  output  1  loader accepts in_data this cycle.
REQ-010 mem_we  output  1  instruction-memory word write strobe.
REQ-011 mem_addr  output  32  byte address of the word being written, always a multiple of 4.
REQ-012 mem_wdata  output  32  word written; byte at mem_addr+k sits in bits [8k+7:8k].
REQ-013 busy  output  1  load in progress; CPU fetch stall.
REQ-014 done  output  1  one-cycle pulse when a load completes.

Function
REQ-015 States: IDLE, RECV, WRITE, DONE.
REQ-016 IDLE: in_ready=0, mem_we=0, busy=0; start=1 latches word_count, clears word and byte indices, moves to RECV, or to DONE if word_count=0.
REQ-017 word_count above MAX_WORDS saturates to MAX_WORDS when latched.
REQ-018 RECV: in_ready=1, busy=1; a byte transfers only on in_valid & in_ready, one byte per cycle maximum.
REQ-019 Byte k (k=0..3) of the current word goes to bits [8k+7:8k] of the assembly register (little-endian).
REQ-020 After the 4th accepted byte the next state is WRITE; a partial word is never written.
REQ-021 WRITE: exactly one cycle, mem_we=1, mem_addr=4*word_idx, mem_wdata=assembled word, in_ready=0, busy=1.
REQ-022 After WRITE: word_idx increments; if it equals the latched count the next state is DONE, else RECV.
REQ-023 DONE: one cycle, done=1, busy=1, in_ready=0; next state IDLE.
REQ-024 start is ignored in every state other than IDLE.
REQ-025 in_valid with in_ready=0 is not consumed; the source holds the byte.
REQ-026 Minimum throughput: 5 cycles per word (4 RECV + 1 WRITE); start-to-done latency with continuous in_valid is 5*N+1 cycles for N words.
REQ-027 mem_addr never exceeds MEM_BYTES-4; no address wrap-around occurs.
REQ-028 mem_we, done, and in_ready are registered outputs, glitch-free, and decoded from state only.

Reset
REQ-029 rst=1 forces IDLE next edge; in_ready=0, mem_we=0, busy=0, done=0, mem_addr=0, mem_wdata=0, indices and latched count=0.
REQ-030 Reset mid-load discards the partial word; no mem_we occurs in the reset cycle or the cycle after.
REQ-031 rst has priority over start and in_valid in the same cycle.

Structure
REQ-032 Shared package imem_pkg holds MEM_BYTES, WORD_BYTES=4, MAX_WORDS and the loader state enumeration.
REQ-033 One sub-module, imem_byte_packer, performs the 4-byte little-endian assembly and byte indexing; the FSM and addressing stay in imem_loader.

Verification
REQ-034 rst, then start with word_count=1 and bytes 0x20,0x10,0x00,0x00 -> one mem_we, mem_addr=0, mem_wdata=0x00001020, done pulse 6 cycles after start.
REQ-035 word_count=3, continuous bytes -> mem_we at addresses 0, 4, 8 in order, busy high for 16 cycles, single done pulse.
REQ-036 in_valid toggling 1/0 each cycle during a 1-word load -> no byte lost or duplicated, mem_wdata is correct, WRITE occurs after the 4th accepted byte.
REQ-037 rst asserted after 2 of 4 bytes -> no mem_we and IDLE next cycle; a fresh start then loads word 0 at address 0 correctly.
REQ-038 word_count=0 -> no mem_we and done one cycle after start; word_count=100 -> exactly 64 writes, last mem_addr=252.
REQ-039 start pulsed during RECV -> ignored; word count and addresses unchanged.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared constants and the loader state encoding for the instruction-memory loader.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: memory geometry (MEM_BYTES, WORD_BYTES, MAX_WORDS) and ld_state_e.
package imem_pkg;

   localparam int MEM_BYTES  = 256;
   localparam int WORD_BYTES = 4;
   localparam int MAX_WORDS  = MEM_BYTES / WORD_BYTES;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RECV,
      ST_WRITE,
      ST_DONE
   } ld_state_e;

endpackage

// File: rtl/imem_byte_packer.sv
// Assembles four consecutive stream bytes into one little-endian 32-bit word.
// Latency: a byte is visible in word_o the cycle after it is accepted.
// Backpressure: none of its own; byte_vld_i must already be the accepted handshake.
//
// Ports:
//   clk_i, rst_i    clock and synchronous active-high reset
//   clr_i           restart assembly at byte 0 (new load)
//   byte_vld_i      byte_dat_i is consumed this cycle
//   byte_dat_i      stream byte
//   word_o          assembly register, byte k in bits [8k+7:8k]
//   word_done_o     the byte consumed this cycle completes the word
module imem_byte_packer
   import imem_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        clr_i,
   input  logic        byte_vld_i,
   input  logic [7:0]  byte_dat_i,
   output logic [31:0] word_o,
   output logic        word_done_o
);

   localparam int IDX_W = $clog2(WORD_BYTES);

   logic [IDX_W-1:0] idx_q;
   logic [31:0]      word_q;

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         idx_q  <= '0;
         word_q <= '0;
      end else if (byte_vld_i) begin
         word_q[8*idx_q +: 8] <= byte_dat_i;
         // Index wraps to 0 naturally after the last byte of a word.
         idx_q                <= idx_q + 1'b1;
      end
   end

   assign word_o      = word_q;
   assign word_done_o = byte_vld_i && (idx_q == IDX_W'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Loads a program from a byte stream into instruction memory, one word write per 4 bytes.
// Latency: 5 cycles per word (4 receive + 1 write); start-to-done 5*N+1 cycles.
// Backpressure: in_ready_o is high only while receiving; the source holds bytes otherwise.
//
// Ports:
//   clk_i, rst_i              clock and synchronous active-high reset
//   start_i, word_count_i     load request and program length in words
//   in_valid_i, in_data_i     byte stream, ascending byte address order
//   in_ready_o                byte accepted when in_valid_i & in_ready_o
//   mem_we_o, mem_addr_o,
//   mem_wdata_o               instruction-memory word write port
//   busy_o                    load in progress (CPU fetch stall)
//   done_o                    one-cycle completion pulse
module imem_loader #(
   parameter int MEM_BYTES = imem_pkg::MEM_BYTES,
   parameter int MAX_WORDS = imem_pkg::MAX_WORDS
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [6:0]  word_count_i,
   input  logic        in_valid_i,
   input  logic [7:0]  in_data_i,
   output logic        in_ready_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic        busy_o,
   output logic        done_o
);

   import imem_pkg::*;

   // Cap the count so the last write address stays within the memory.
   localparam int CAP_WORDS = (MAX_WORDS * WORD_BYTES > MEM_BYTES) ?
                              (MEM_BYTES / WORD_BYTES) : MAX_WORDS;
   localparam logic [6:0] CAP = 7'(CAP_WORDS);

   ld_state_e   state_q, state_d;
   logic [6:0]  cnt_q, cnt_d;
   logic [6:0]  widx_q, widx_d;
   logic [31:0] addr_q, addr_d;
   logic        in_ready_q, mem_we_q, busy_q, done_q;

   logic        pk_clr;
   logic        byte_acc;
   logic        word_done;
   logic [31:0] pk_word;

   assign byte_acc = in_valid_i && in_ready_q;

   imem_byte_packer u_packer (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .clr_i       (pk_clr),
      .byte_vld_i  (byte_acc),
      .byte_dat_i  (in_data_i),
      .word_o      (pk_word),
      .word_done_o (word_done)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      widx_d  = widx_q;
      addr_d  = addr_q;
      pk_clr  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               cnt_d   = (word_count_i > CAP) ? CAP : word_count_i;
               widx_d  = '0;
               pk_clr  = 1'b1;
               state_d = (word_count_i == 7'd0) ? ST_DONE : ST_RECV;
            end
         end
         ST_RECV: begin
            if (word_done) begin
               addr_d  = {23'd0, widx_q, 2'b00};
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            widx_d  = widx_q + 7'd1;
            state_d = (widx_d == cnt_q) ? ST_DONE : ST_RECV;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they change only on the clock edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         widx_q     <= '0;
         addr_q     <= '0;
         in_ready_q <= 1'b0;
         mem_we_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         widx_q     <= widx_d;
         addr_q     <= addr_d;
         in_ready_q <= (state_d == ST_RECV);
         mem_we_q   <= (state_d == ST_WRITE);
         busy_q     <= (state_d != ST_IDLE);
         done_q     <= (state_d == ST_DONE);
      end
   end

   assign in_ready_o  = in_ready_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = pk_word;
   assign busy_o      = busy_q;
   assign done_o      = done_q;

endmodule
